// File: rtl/pipe_rr_arbiter_if.sv
// pipe_rr_arbiter_if: requester-side bundle of the shared-pipeline arbiter.
// Carries stall enable, requests, data words, grants and the tail response.
interface pipe_rr_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) ();
   logic                  EN;
   logic [NREQ-1:0]       REQ;
   logic [NREQ*WIDTH-1:0] DIN;
   logic [NREQ-1:0]       GNT;
   logic [WIDTH-1:0]      Q;
   logic [NREQ-1:0]       RESP_VLD;
   logic                  BUSY;

   modport master (
      output EN, REQ, DIN,
      input  GNT, Q, RESP_VLD, BUSY
   );

   modport slave (
      input  EN, REQ, DIN,
      output GNT, Q, RESP_VLD, BUSY
   );
endinterface

// File: rtl/pipe_rr_arbiter.sv
// pipe_rr_arbiter: round-robin grant of NREQ requesters into one shared
// DEPTH-stage register pipeline, returning each word tagged at the tail.
module pipe_rr_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input logic              CK,
   input logic              RST_N,
   pipe_rr_arbiter_if.slave bus
);
   localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef struct packed {
      logic             vld;
      logic [TW-1:0]    tag;
      logic [WIDTH-1:0] dat;
   } stage_t;

   stage_t           stg [DEPTH];
   logic [TW-1:0]    ptr;
   logic [TW-1:0]    gidx;
   logic             found;
   logic [NREQ-1:0]  gnt;
   logic [NREQ-1:0]  resp;
   logic [DEPTH-1:0] vlds;
   int               j;

   // first requester at or above ptr, wrapping
   always_comb begin
      gidx  = '0;
      found = 1'b0;
      j     = 0;
      for (int o = 0; o < NREQ; o++) begin
         j = (int'(ptr) + o) % NREQ;
         if (!found && bus.REQ[j]) begin
            found = 1'b1;
            gidx  = TW'(j);
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (found && bus.EN && RST_N)
         gnt[gidx] = 1'b1;
   end

   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) begin
         ptr <= '0;
         for (int k = 0; k < DEPTH; k++)
            stg[k] <= '0;
      end else if (bus.EN) begin
         if (|gnt)
            stg[0] <= {1'b1, gidx,
                       bus.DIN[int'(gidx)*WIDTH +: WIDTH]};
         else
            stg[0] <= '0;
         for (int k = 1; k < DEPTH; k++)
            stg[k] <= stg[k-1];
         if (|gnt)
            ptr <= (int'(gidx) == NREQ-1) ? '0 : gidx + TW'(1);
      end
   end

   // a stalled tail is held back so it is reported exactly once
   always_comb begin
      resp = '0;
      for (int k = 0; k < DEPTH; k++)
         vlds[k] = stg[k].vld;
      if (stg[DEPTH-1].vld && bus.EN)
         resp[stg[DEPTH-1].tag] = 1'b1;
   end

   assign bus.GNT      = gnt;
   assign bus.Q        = stg[DEPTH-1].dat;
   assign bus.RESP_VLD = resp;
   assign bus.BUSY     = |vlds;
endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// tb_pipe_rr_arbiter: directed stimulus with a queue-based reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_pipe_rr_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int DEPTH = 2;

   logic CK = 1'b0;
   logic RST_N;
   int   pass_cnt = 0;
   int   total = 0;

   always #5 CK = ~CK;

   pipe_rr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   pipe_rr_arbiter #(
      .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)
   ) dut (
      .CK(CK),
      .RST_N(RST_N),
      .bus(bus)
   );

   typedef struct {
      bit               v;
      logic [WIDTH-1:0] d;
      int               t;
   } ent_t;

   ent_t pipe[$];
   int   mp;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                  nm, act, exp, $time);
   endtask

   function automatic int pick();
      for (int o = 0; o < NREQ; o++) begin
         int jj = (mp + o) % NREQ;
         if (bus.REQ[jj]) return jj;
      end
      return -1;
   endfunction

   function automatic logic [31:0] exp_gnt();
      int g;
      if (!bus.EN || !RST_N) return 0;
      g = pick();
      return (g < 0) ? 0 : (32'd1 << g);
   endfunction

   function automatic logic [31:0] exp_busy();
      foreach (pipe[i]) if (pipe[i].v) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] exp_resp();
      if (pipe[0].v && bus.EN) return 32'd1 << pipe[0].t;
      return 0;
   endfunction

   task automatic model_reset();
      ent_t e;
      e.v = 1'b0; e.d = '0; e.t = 0;
      mp = 0;
      pipe.delete();
      for (int i = 0; i < DEPTH; i++) pipe.push_back(e);
   endtask

   // reference: words enter a DEPTH-long queue and leave in grant order
   initial begin
      ent_t e;
      int   g;
      model_reset();
      forever begin
         @(posedge CK or negedge RST_N);
         if (!RST_N) begin
            model_reset();
         end else if (bus.EN) begin
            g   = pick();
            e.v = (g >= 0);
            e.t = (g >= 0) ? g : 0;
            e.d = (g >= 0) ? bus.DIN[g*WIDTH +: WIDTH] : '0;
            pipe.push_back(e);
            e = pipe.pop_front();
            if (g >= 0) mp = (g + 1) % NREQ;
         end
      end
   end

   initial begin
      forever begin
         @(negedge CK);
         if (RST_N) begin
            chk("m_gnt", 32'(bus.GNT), exp_gnt());
            chk("m_resp", 32'(bus.RESP_VLD), exp_resp());
            chk("m_busy", 32'(bus.BUSY), exp_busy());
            if (pipe[0].v)
               chk("m_q", 32'(bus.Q), 32'(pipe[0].d));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge CK);
      #1;
   endtask

   task automatic setd(input int i, input logic [WIDTH-1:0] v);
      bus.DIN[i*WIDTH +: WIDTH] = v;
   endtask

   task automatic pulse_rst();
      RST_N = 1'b0;
      #1;
      RST_N = 1'b1;
   endtask

   logic [3:0] eg [7];
   logic [7:0] eq [5];

   initial begin
      eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
             4'b0001, 4'b0010, 4'b0100};
      eq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
      RST_N   = 1'b0;
      bus.EN  = 1'b1;
      bus.REQ = 4'b0001;
      bus.DIN = '0;
      #2;
      chk("rst_gnt", 32'(bus.GNT), 0);
      chk("rst_q", 32'(bus.Q), 0);
      chk("rst_resp", 32'(bus.RESP_VLD), 0);
      chk("rst_busy", 32'(bus.BUSY), 0);
      step();
      RST_N   = 1'b1;
      bus.REQ = '0;

      // single request
      step();
      setd(0, 8'hA5);
      bus.REQ = 4'b0001;
      #1;
      chk("t1_gnt", 32'(bus.GNT), 32'h1);
      chk("t1_busy_pre", 32'(bus.BUSY), 0);
      step();
      bus.REQ = '0;
      #1;
      chk("t1_busy_a", 32'(bus.BUSY), 1);
      chk("t1_resp_early", 32'(bus.RESP_VLD), 0);
      step();
      #1;
      chk("t1_q", 32'(bus.Q), 32'hA5);
      chk("t1_resp", 32'(bus.RESP_VLD), 32'h1);
      chk("t1_busy_b", 32'(bus.BUSY), 1);
      step();
      #1;
      chk("t1_resp_end", 32'(bus.RESP_VLD), 0);
      chk("t1_busy_end", 32'(bus.BUSY), 0);

      // all requesting, round-robin order
      step();
      pulse_rst();
      for (int i = 0; i < NREQ; i++) setd(i, 8'(8'h10 + i));
      bus.REQ = 4'b1111;
      for (int i = 0; i < 7; i++) begin
         #1;
         chk("t2_gnt", 32'(bus.GNT), 32'(eg[i]));
         if (i >= 2) begin
            chk("t2_q", 32'(bus.Q), 32'(eq[i-2]));
            chk("t2_resp", 32'(bus.RESP_VLD), 32'(eg[i-2]));
         end
         step();
      end
      bus.REQ = '0;
      step(); step(); step();

      // stall with a word in each stage
      pulse_rst();
      setd(0, 8'h20);
      setd(1, 8'h21);
      bus.REQ = 4'b0011;
      #1;
      chk("t3_g0", 32'(bus.GNT), 32'h1);
      step();
      #1;
      chk("t3_g1", 32'(bus.GNT), 32'h2);
      step();
      bus.EN  = 1'b0;
      bus.REQ = 4'b0100;
      setd(2, 8'h22);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t3_st_gnt", 32'(bus.GNT), 0);
         chk("t3_st_resp", 32'(bus.RESP_VLD), 0);
         chk("t3_st_q", 32'(bus.Q), 32'h20);
         chk("t3_st_busy", 32'(bus.BUSY), 1);
         step();
      end
      bus.EN = 1'b1;
      #1;
      chk("t3_gnt", 32'(bus.GNT), 32'h4);
      chk("t3_resp0", 32'(bus.RESP_VLD), 32'h1);
      chk("t3_q0", 32'(bus.Q), 32'h20);
      step();
      bus.REQ = '0;
      #1;
      chk("t3_resp1", 32'(bus.RESP_VLD), 32'h2);
      chk("t3_q1", 32'(bus.Q), 32'h21);
      step();
      #1;
      chk("t3_resp2", 32'(bus.RESP_VLD), 32'h4);
      chk("t3_q2", 32'(bus.Q), 32'h22);
      step();
      #1;
      chk("t3_resp_end", 32'(bus.RESP_VLD), 0);
      chk("t3_busy_end", 32'(bus.BUSY), 0);

      // pointer wrap from requester 3
      bus.REQ = 4'b1000;
      setd(3, 8'h33);
      #1;
      chk("t4_g3", 32'(bus.GNT), 32'h8);
      step();
      bus.REQ = 4'b1001;
      setd(0, 8'h30);
      #1;
      chk("t4_wrap", 32'(bus.GNT), 32'h1);
      step();
      #1;
      chk("t4_next", 32'(bus.GNT), 32'h8);
      step();
      bus.REQ = '0;
      step(); step();

      // asynchronous reset with two words in flight
      setd(0, 8'h40);
      setd(1, 8'h41);
      bus.REQ = 4'b0011;
      #1;
      chk("t5_g0", 32'(bus.GNT), 32'h1);
      step();
      #1;
      chk("t5_g1", 32'(bus.GNT), 32'h2);
      step();
      RST_N = 1'b0;
      #1;
      chk("t5_busy", 32'(bus.BUSY), 0);
      chk("t5_q", 32'(bus.Q), 0);
      chk("t5_resp", 32'(bus.RESP_VLD), 0);
      chk("t5_gnt", 32'(bus.GNT), 0);
      RST_N   = 1'b1;
      bus.REQ = 4'b1010;
      setd(1, 8'h51);
      setd(3, 8'h53);
      #1;
      chk("t5_p0", 32'(bus.GNT), 32'h2);
      bus.REQ = 4'b0100;
      setd(2, 8'h42);
      #1;
      chk("t5_g2", 32'(bus.GNT), 32'h4);
      step();
      bus.REQ = '0;
      #1;
      chk("t5_resp_a", 32'(bus.RESP_VLD), 0);
      chk("t5_busy_a", 32'(bus.BUSY), 1);
      step();
      #1;
      chk("t5_q42", 32'(bus.Q), 32'h42);
      chk("t5_resp_b", 32'(bus.RESP_VLD), 32'h4);
      step();
      #1;
      chk("t5_resp_end", 32'(bus.RESP_VLD), 0);

      // requester 1 withdraws before being served
      setd(0, 8'h50);
      setd(1, 8'h5F);
      bus.REQ = 4'b0011;
      #1;
      chk("t6_g0", 32'(bus.GNT), 32'h1);
      step();
      bus.REQ = '0;
      #1;
      chk("t6_gnt_drop", 32'(bus.GNT), 0);
      chk("t6_resp_a", 32'(bus.RESP_VLD), 0);
      step();
      #1;
      chk("t6_q", 32'(bus.Q), 32'h50);
      chk("t6_resp_b", 32'(bus.RESP_VLD), 32'h1);
      chk("t6_gnt_b", 32'(bus.GNT), 0);
      step();
      #1;
      chk("t6_resp_end", 32'(bus.RESP_VLD), 0);
      chk("t6_busy_end", 32'(bus.BUSY), 0);
      step(); step();

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/pipe_rr_arbiter.md
Name: pipe_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one DEPTH-stage register pipeline among NREQ requesters.
- Grants at most one requester per cycle and launches its data word into the shared pipeline together with a requester tag.
- Routes the word back out as a one-hot response at the pipeline tail.
- Sits in front of the shared staged-register datapath; the pipeline stages are all nonblocking registered stages inside this block.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, data word width
DEPTH, 2, shared pipeline stages (>=1)

Ports:
CK  input  1  clock, all state updates on rising edge
RST_N  input  1  asynchronous active-low reset
EN  input  1  pipeline advance enable; 0 = stall, no grants, all stages hold
REQ  input  NREQ  per-requester request; held with DIN until granted
DIN  input  NREQ*WIDTH  requester data, slice i = DIN[i*WIDTH +: WIDTH]
GNT  output  NREQ  one-hot grant, combinational, valid this cycle
Q  output  WIDTH  data at pipeline tail
RESP_VLD  output  NREQ  one-hot: Q belongs to requester i
BUSY  output  1  any pipeline stage valid

Behaviour:
- Clock and reset: one clock CK; reset is asynchronous and active-low on RST_N.
- Reset values (RST_N low, immediate, independent of CK):
  - All stage valid bits 0, stage data and tags 0.
  - Round-robin pointer = 0, so requester 0 has highest priority first.
  - Q = 0, RESP_VLD = 0, BUSY = 0, GNT = 0.
- Arbitration (combinational):
  - If EN = 1 and REQ != 0, GNT = first set REQ bit searching upward from pointer P, wrapping NREQ-1 -> 0.
  - Otherwise GNT = 0.
  - GNT is always one-hot or zero.
- Handshake:
  - A transfer occurs on a rising edge where GNT[i] = 1.
  - Requester i must hold REQ[i] and its DIN slice stable until it sees GNT[i] high at an edge.
  - REQ[i] may then drop or stay high for back-to-back use; that requester is then subject to round-robin.
  - A request withdrawn before grant is legal and is simply lost.
- Pointer update:
  - On a transfer edge, P <= (granted index + 1) mod NREQ.
  - With no transfer, P holds.
- Pipeline (advances only on edges with EN = 1):
  - stage1 <= {valid = |GNT, data = granted DIN slice, tag = granted index}.
  - stage k <= stage k-1 for k = 2..DEPTH.
  - With EN = 0, all stages hold their contents.
- Latency: a word granted at edge k appears on Q after edge k+DEPTH-1.
  - DEPTH = 1 gives Q one cycle after the grant cycle.
  - DEPTH = 2 gives Q two cycles after the grant cycle.
- Outputs:
  - Q = tail stage data.
  - RESP_VLD = onehot(tail tag) when tail valid AND EN = 1, else 0. A stalled tail is never reported twice.
  - BUSY = OR of all stage valid bits.
- Throughput: one word per cycle when EN stays high; words exit in grant order.
- Fairness: with all REQ held high, grants cycle 0,1,..,NREQ-1,0. Maximum wait for a held request is NREQ-1 grant cycles of other requesters while EN = 1.
- Simultaneous events:
  - A grant and a tail exit in the same cycle are independent.
  - A new REQ rising in the same cycle as P moves is arbitrated against the new P on the next cycle.
- Reset mid-operation:
  - In-flight words are discarded and P returns to 0.
  - Requesters must re-request after RST_N deasserts.
  - No RESP_VLD is issued for discarded words.
- Width rules: tag width = clog2(NREQ), minimum 1. DIN slices are passed unmodified.

Test Plan:
1. Reset then single request: REQ=0001, DIN slice0=8'hA5 -> GNT=0001 in that cycle; two cycles later Q=8'hA5, RESP_VLD=0001 for one cycle; BUSY high for exactly 2 cycles.
2. All requesting: REQ=1111 held, slices 8'h10/8'h11/8'h12/8'h13 -> GNT sequence 0001, 0010, 0100, 1000, 0001; Q stream 10, 11, 12, 13, 10 with matching RESP_VLD.
3. Stall: one word in each stage, then EN=0 for 3 cycles -> GNT=0, RESP_VLD=0, Q constant, BUSY=1. After EN=1, both words exit in order with no duplicate RESP_VLD.
4. Pointer wrap: grant requester 3 alone, then REQ=1001 -> GNT=0001 (P=0 after wrap); next cycle GNT=1000.
5. Reset mid-flight: two words in pipeline, pulse RST_N low for 1 ns asynchronously between edges -> BUSY, Q, RESP_VLD and GNT go 0 immediately. No response ever issued for those words. Next REQ=0100 is granted with P=0 behaviour.
6. Withdrawn request: REQ=0010 asserted while requester 0 is granted, then dropped before its grant -> GNT[1] never asserts, no RESP_VLD[1].
